// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - shared state encodings and 100 MHz timing defaults for the button event decoder
package btn_evt_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_PRESS = PRESS,
    ST_HOLD  = HOLD
  } state_e;

  localparam int DEF_LONG_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/btn_evt_timer.sv
// rtl/btn_evt_timer.sv - hold-time counter with a registered terminal-count flag
module btn_evt_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt_q;
    if (clear) begin
      cnt_n = '0;
    end else if (enable) begin
      cnt_n = cnt_q + CNT_W'(1);
    end
  end

  // hit mirrors (cnt == terminal) for the value being loaded, so the FSM sees it without a compare delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hit   <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      hit   <= (cnt_n == terminal);
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - press/release/click/long/repeat pulse decoder for a debounced button
// Optional HOLD auto-repeat is built only when BTN_EVT_REPEAT_EN is defined.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic debounced,
  output logic press,
  output logic release_evt,
  output logic short_click,
  output logic long_press,
  output logic repeat_evt,
  output logic holding
);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  state_e           state_q;
  state_e           state_n;
  logic             clear;
  logic             enable;
  logic             hit;
  logic [CNT_W-1:0] terminal;
  logic             press_n;
  logic             release_n;
  logic             short_n;
  logic             long_n;
  logic             repeat_n;

  // Terminal tracks the current state; every state change also clears, so hit never leaks across states.
`ifdef BTN_EVT_REPEAT_EN
  assign terminal = (state_q == ST_HOLD) ? CNT_W'(REPEAT_CYCLES - 1) : CNT_W'(LONG_CYCLES - 1);
`else
  assign terminal = CNT_W'(LONG_CYCLES - 1);
`endif

  btn_evt_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .enable  (enable),
    .terminal(terminal),
    .hit     (hit)
  );

  always_comb begin
    state_n   = state_q;
    clear     = 1'b0;
    enable    = 1'b0;
    press_n   = 1'b0;
    release_n = 1'b0;
    short_n   = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (debounced) begin
          state_n = ST_PRESS;
          press_n = 1'b1;
          clear   = 1'b1;
        end
      end
      ST_PRESS: begin
        if (!debounced) begin
          state_n   = ST_IDLE;
          release_n = 1'b1;
          short_n   = 1'b1;
          clear     = 1'b1;
        end else if (hit) begin
          state_n = ST_HOLD;
          long_n  = 1'b1;
          clear   = 1'b1;
        end else begin
          enable = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!debounced) begin
          state_n   = ST_IDLE;
          release_n = 1'b1;
          clear     = 1'b1;
        end
`ifdef BTN_EVT_REPEAT_EN
        else if (hit) begin
          repeat_n = 1'b1;
          clear    = 1'b1;
        end else begin
          enable = 1'b1;
        end
`endif
      end
      default: begin
        state_n = ST_IDLE;
        clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      press       <= 1'b0;
      release_evt <= 1'b0;
      short_click <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
      holding     <= 1'b0;
    end else begin
      state_q     <= state_n;
      press       <= press_n;
      release_evt <= release_n;
      short_click <= short_n;
      long_press  <= long_n;
      repeat_evt  <= repeat_n;
      holding     <= (state_n == ST_HOLD);
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed self-checking bench for button_event_decoder (LONG=8, REPEAT=4)
module tb_button_event_decoder;

`ifdef BTN_EVT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic debounced = 1'b0;
  logic press, release_evt, short_click, long_press, repeat_evt, holding;
  int   total = 0;
  int   bad = 0;

  button_event_decoder #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .debounced  (debounced),
    .press      (press),
    .release_evt(release_evt),
    .short_click(short_click),
    .long_press (long_press),
    .repeat_evt (repeat_evt),
    .holding    (holding)
  );

  always #5 clk = ~clk;

  // {press, release, short_click, long_press, repeat, holding}
  function automatic logic [5:0] obs();
    return {press, release_evt, short_click, long_press, repeat_evt, holding};
  endfunction

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst_n = 1'b0;
    debounced = 1'b0;
    #3;
    got = obs();
    total++;
    if (got !== 6'b0) begin
      bad++;
      $display("FAIL reset_hold got=%b want=%b", got, 6'b0);
    end
    settle(2);
    rst_n = 1'b1;
    settle(2);
    got = obs();
    total++;
    if (got !== 6'b0) begin
      bad++;
      $display("FAIL reset_idle got=%b want=%b", got, 6'b0);
    end
  endtask

  task automatic test_short_tap();
    logic [5:0] got, exp;
    debounced = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      got = obs();
      exp = {e == 1, e == 4, e == 4, 1'b0, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL short_tap edge=%0d got=%b want=%b", e, got, exp);
      end
      if (e == 3) debounced = 1'b0;
    end
  endtask

  task automatic test_long_hold();
    logic [5:0] got, exp;
    debounced = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk);
      #1;
      got = obs();
      exp = {e == 1, e == 21, 1'b0, e == 9, REP_EN && (e == 13 || e == 17), e >= 9 && e <= 20};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL long_hold edge=%0d got=%b want=%b", e, got, exp);
      end
      if (e == 20) debounced = 1'b0;
    end
  endtask

  task automatic test_tie();
    logic [5:0] got, exp;
    debounced = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      got = obs();
      exp = {e == 1, e == 9, e == 9, 1'b0, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL tie_release edge=%0d got=%b want=%b", e, got, exp);
      end
      if (e == 8) debounced = 1'b0;
    end
  endtask

  task automatic test_just_long();
    logic [5:0] got, exp;
    debounced = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      got = obs();
      exp = {e == 1, e == 10, 1'b0, e == 9, 1'b0, e == 9};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL just_long edge=%0d got=%b want=%b", e, got, exp);
      end
      if (e == 9) debounced = 1'b0;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] got, exp;
    debounced = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      @(posedge clk);
      #1;
      got = obs();
      if (e <= 12)
        exp = {e == 1, 1'b0, 1'b0, e == 9, 1'b0, e >= 9};
      else if (e <= 14)
        exp = 6'b0;
      else
        exp = {e == 15, e == 27, 1'b0, e == 23, 1'b0, e >= 23 && e <= 26};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_mid_hold edge=%0d got=%b want=%b", e, got, exp);
      end
      if (e == 12) begin
        rst_n = 1'b0;
        #1;
        got = obs();
        total++;
        if (got !== 6'b0) begin
          bad++;
          $display("FAIL reset_async_clear got=%b want=%b", got, 6'b0);
        end
      end
      if (e == 14) rst_n = 1'b1;
      if (e == 26) debounced = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got, exp;
    debounced = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      got = obs();
      exp = {e == 1 || e == 3, e == 2 || e == 4, e == 2 || e == 4, 1'b0, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL back_to_back edge=%0d got=%b want=%b", e, got, exp);
      end
      debounced = (e == 2);
    end
  endtask

  initial begin
    test_reset();
    test_short_tap();
    settle(3);
    test_long_hold();
    settle(3);
    test_tie();
    settle(3);
    test_just_long();
    settle(3);
    test_reset_mid_hold();
    settle(3);
    test_back_to_back();
    settle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the clean, synchronous `debounced` level produced by the push-button debouncer (1 = button pressed) and turns it into one-cycle event pulses for the game/control logic. The events are press, release, short click, long press and auto-repeat. It sits between each debouncer instance and the top-level controller, so downstream logic never has to do its own edge detection or hold timing.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold time, in clock cycles, before `long_press` fires (0.5 s at 100 MHz). Must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period in HOLD, in cycles. Must be ≥ 2.
- `CNT_W`, default 26: counter width. Must satisfy 2^CNT_W ≥ max(LONG_CYCLES, REPEAT_CYCLES).
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `debounced` input 1: clean button level from the debouncer; already synchronous to `clk`.
- `press` output 1: one-cycle pulse on the press edge.
- `release` output 1: one-cycle pulse on the release edge, from any pressed state.
- `short_click` output 1: one-cycle pulse, coincident with `release`, only when the button is released before the long threshold.
- `long_press` output 1: one-cycle pulse when the hold reaches LONG_CYCLES.
- `repeat` output 1: one-cycle pulse every REPEAT_CYCLES while in HOLD.
- `holding` output 1: level, 1 while in HOLD.

## Operation
- FSM states:
  - IDLE: released.
  - PRESS: pressed, below the long threshold.
  - HOLD: long threshold reached.
- Counter `cnt` (CNT_W bits) is cleared on every state change and increments once per cycle in PRESS and HOLD.
- IDLE:
  - `debounced`=1 → PRESS, `press`=1.
  - Otherwise stay in IDLE.
- PRESS:
  - `debounced`=0 → IDLE, with `release`=1 and `short_click`=1.
  - Else if `cnt`==LONG_CYCLES-1 → HOLD, `long_press`=1.
  - Else `cnt`++.
- HOLD:
  - `debounced`=0 → IDLE, `release`=1.
  - Else if `cnt`==REPEAT_CYCLES-1 → `repeat`=1 and `cnt` is cleared; stay in HOLD.
  - Else `cnt`++.
- Release in the same cycle as a terminal count: release wins. No `long_press` and no `repeat` is emitted in that case; `short_click` still fires from PRESS.
- The counter never wraps. It is compared against terminal−1 and cleared, so overflow cannot occur when the width rule holds.
- Illegal or unused state encodings go to IDLE on the next edge with all pulses 0.

## Timing
- All outputs are registered. Reset value of every output, of `cnt` and of the state is 0 / IDLE.
- Press latency: if `debounced` is first sampled high at edge k, `press` is high for the cycle following edge k.
- Release latency: one cycle, same rule as press.
- Pulse width: every pulse output is high for exactly one cycle. No two pulses repeat on consecutive cycles, except `release` and `short_click`, which are deliberately coincident.
- `long_press` timing: `press` at edge k gives `long_press` at edge k+LONG_CYCLES.
- `repeat` timing: the first `repeat` comes REPEAT_CYCLES edges after `long_press`; later ones are spaced REPEAT_CYCLES apart.
- `holding` rises with `long_press` and falls with `release`.
- Reset mid-operation:
  - Asserting `rst_n` forces IDLE and zeroes all outputs immediately, with no `release` pulse.
  - If `debounced` is still 1 when reset deasserts, the first edge reports a fresh `press`.

## Configuration
- `BTN_EVT_REPEAT_EN`:
  - Defined: HOLD auto-repeat is active as described above.
  - Undefined: HOLD only waits for release. `cnt` is held at 0, `repeat` is tied to 0, and the repeat comparator is not built. All other behaviour, including `long_press` and `holding`, is unchanged.

## Structure
- Shared package / header `btn_evt_pkg` holds:
  - the state encodings as 2-bit localparams: IDLE=0, PRESS=1, HOLD=2;
  - the default LONG_CYCLES and REPEAT_CYCLES for a 100 MHz clock, for reuse by the top level and the bench.
- One sub-module, `btn_evt_timer`: a CNT_W-bit counter with synchronous `clear`, `enable` and a `terminal` input, producing a registered `hit` flag.
- The FSM and output registers stay in `button_event_decoder`.

## Test plan
Bench parameters: LONG_CYCLES=8, REPEAT_CYCLES=4.
- Short tap: `debounced` high for 3 cycles → one `press`, then `release`+`short_click` together one cycle after the fall. No `long_press`.
- Long hold: `debounced` high for 20 cycles (repeat enabled) → `press` at edge 1 and `long_press` at edge 9. `repeat` at edges 13 and 17. `holding`=1 from edge 9 until `release` at edge 21; no `short_click`.
- Tie case: `debounced` falls on exactly the edge where `cnt`=7 → `release`+`short_click`, and no `long_press`.
- Macro off: same 20-cycle hold → `long_press` at edge 9, `repeat` stays 0 throughout, and `release` has no `short_click`.
- Reset mid-hold: `rst_n` pulled low at cycle 12 while `debounced`=1, released at cycle 14 → outputs are 0 during reset with no `release`. `press` fires one edge after reset release, and `long_press` follows 8 edges later.
